// File: rtl/h14tx_tmds_lane_encoder.sv
// h14tx_tmds_lane_encoder
// Multi-lane HDMI 1.4 TMDS channel encoder. Per lane it produces 10-bit symbols for video
// (transition-minimised, DC-balanced), control, TERC4 data island and both guard bands.
// Two-stage pipeline: stage 1 registers inputs plus the transition-minimised word and its
// ones/zeros counts, stage 2 selects the symbol and updates that lane's running disparity.
// Optional feature macro: H14TX_TMDS_TERC4_EN. When undefined, the TERC4 table and aux path
// are removed, ISLAND/ISLAND_GB encode the ctrl inputs and i_aux is ignored.

module h14tx_tmds_lane_encoder #(
    parameter int unsigned LANES  = 3,
    parameter int unsigned DISP_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_enable,
    input  logic [2:0]                i_mode,
    input  logic [8*LANES-1:0]        i_video,
    input  logic [2*LANES-1:0]        i_ctrl,
    input  logic [4*LANES-1:0]        i_aux,
    output logic [10*LANES-1:0]       o_symbol,
    output logic [DISP_W*LANES-1:0]   o_disparity
);

    localparam logic [2:0] MODE_CTRL      = 3'd0;
    localparam logic [2:0] MODE_VIDEO     = 3'd1;
    localparam logic [2:0] MODE_ISLAND    = 3'd2;
    localparam logic [2:0] MODE_VIDEO_GB  = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GB = 3'd4;

    localparam logic [9:0] SYM_GB_EVEN = 10'b1011001100;
    localparam logic [9:0] SYM_GB_ODD  = 10'b0100110011;

    // Control-period symbols, indexed by {D1, D0}.
    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] q;
        q = 10'b1101010100;
        unique case (c)
            2'b00: q = 10'b1101010100;
            2'b01: q = 10'b0010101011;
            2'b10: q = 10'b0101010100;
            2'b11: q = 10'b1010101011;
        endcase
        return q;
    endfunction

`ifdef H14TX_TMDS_TERC4_EN
    // TERC4 data-island symbols, indexed by the aux nibble.
    function automatic logic [9:0] terc4_sym(input logic [3:0] d);
        logic [9:0] q;
        q = 10'b1010011100;
        unique case (d)
            4'h0: q = 10'b1010011100;
            4'h1: q = 10'b1001100011;
            4'h2: q = 10'b1011100100;
            4'h3: q = 10'b1011100010;
            4'h4: q = 10'b0101110001;
            4'h5: q = 10'b0100011110;
            4'h6: q = 10'b0110001110;
            4'h7: q = 10'b0100111100;
            4'h8: q = 10'b1011001100;
            4'h9: q = 10'b0100111001;
            4'hA: q = 10'b0110011100;
            4'hB: q = 10'b1011000110;
            4'hC: q = 10'b1010001110;
            4'hD: q = 10'b1001110001;
            4'hE: q = 10'b0101100011;
            4'hF: q = 10'b1011000011;
        endcase
        return q;
    endfunction
`else
    logic w_unused_aux;
    assign w_unused_aux = ^i_aux;
`endif

    // Stage-1 state shared by all lanes: a flushed or reset stage encodes nothing.
    logic       r_valid;
    logic [2:0] r_mode;

    // Stage 1 shared control: capture period, flush on enable low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_CTRL;
        end else if (!i_enable) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_CTRL;
        end else begin
            r_valid <= 1'b1;
            r_mode  <= i_mode;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam logic [9:0] SYM_GB_VIDEO = ((g % 2) == 0) ? SYM_GB_EVEN : SYM_GB_ODD;
        localparam bit         IS_LANE0     = (g == 0);

        logic [7:0] w_video;
        logic [3:0] w_pop;
        logic       w_use_xnor;
        logic [8:0] w_ir;
        logic [4:0] w_n1;
        logic [4:0] w_n0;

        logic [8:0] r_ir;
        logic [4:0] r_n1;
        logic [4:0] r_n0;
        logic [1:0] r_ctrl;
`ifdef H14TX_TMDS_TERC4_EN
        logic [3:0] r_aux;
`endif

        logic [DISP_W-1:0] w_n1x;
        logic [DISP_W-1:0] w_n0x;
        logic [DISP_W-1:0] w_two;
        logic              w_disp_pos;
        logic              w_disp_neg;
        logic [9:0]        w_sym_d;
        logic [DISP_W-1:0] w_disp_d;

        logic [9:0]        r_sym;
        logic [DISP_W-1:0] r_disp;

        assign w_video = i_video[8*g +: 8];

        // Stage 1 combinational: transition-minimised word and its ones/zeros counts.
        always_comb begin
            w_pop = '0;
            for (int i = 0; i < 8; i++) begin
                w_pop = w_pop + {3'b000, w_video[i]};
            end
            // Tie-break on bit 0 when the byte is exactly half ones.
            w_use_xnor = (w_pop > 4'd4) || ((w_pop == 4'd4) && !w_video[0]);
            w_ir       = '0;
            w_ir[0]    = w_video[0];
            for (int i = 1; i < 8; i++) begin
                w_ir[i] = w_use_xnor ? ~(w_ir[i-1] ^ w_video[i]) : (w_ir[i-1] ^ w_video[i]);
            end
            w_ir[8] = ~w_use_xnor;
            w_n1    = '0;
            for (int i = 0; i < 8; i++) begin
                w_n1 = w_n1 + {4'b0000, w_ir[i]};
            end
            w_n0 = 5'd8 - w_n1;
        end

        // Stage 1 per-lane registers; cleared by reset and by a flush.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ir   <= '0;
                r_n1   <= '0;
                r_n0   <= '0;
                r_ctrl <= '0;
`ifdef H14TX_TMDS_TERC4_EN
                r_aux  <= '0;
`endif
            end else if (!i_enable) begin
                r_ir   <= '0;
                r_n1   <= '0;
                r_n0   <= '0;
                r_ctrl <= '0;
`ifdef H14TX_TMDS_TERC4_EN
                r_aux  <= '0;
`endif
            end else begin
                r_ir   <= w_ir;
                r_n1   <= w_n1;
                r_n0   <= w_n0;
                r_ctrl <= i_ctrl[2*g +: 2];
`ifdef H14TX_TMDS_TERC4_EN
                r_aux  <= i_aux[4*g +: 4];
`endif
            end
        end

        assign w_n1x      = DISP_W'(r_n1);
        assign w_n0x      = DISP_W'(r_n0);
        assign w_two      = {{(DISP_W-2){1'b0}}, 2'b10};
        assign w_disp_neg = r_disp[DISP_W-1];
        assign w_disp_pos = !r_disp[DISP_W-1] && (r_disp != '0);

        // Stage 2 combinational: symbol select and two's-complement disparity update.
        always_comb begin
            w_sym_d  = '0;
            w_disp_d = '0;
            if (r_valid) begin
                case (r_mode)
                    MODE_VIDEO: begin
                        if ((r_disp == '0) || (r_n1 == r_n0)) begin
                            w_sym_d  = {~r_ir[8], r_ir[8], r_ir[8] ? r_ir[7:0] : ~r_ir[7:0]};
                            w_disp_d = r_ir[8] ? (r_disp + w_n1x - w_n0x)
                                               : (r_disp + w_n0x - w_n1x);
                        end else if ((w_disp_pos && (r_n1 > r_n0)) ||
                                     (w_disp_neg && (r_n1 < r_n0))) begin
                            w_sym_d  = {1'b1, r_ir[8], ~r_ir[7:0]};
                            w_disp_d = r_disp + w_n0x - w_n1x + (r_ir[8] ? w_two : '0);
                        end else begin
                            w_sym_d  = {1'b0, r_ir[8], r_ir[7:0]};
                            w_disp_d = r_disp + w_n1x - w_n0x - (r_ir[8] ? '0 : w_two);
                        end
                    end
                    MODE_VIDEO_GB: w_sym_d = SYM_GB_VIDEO;
`ifdef H14TX_TMDS_TERC4_EN
                    MODE_ISLAND:    w_sym_d = terc4_sym(r_aux);
                    MODE_ISLAND_GB: w_sym_d = IS_LANE0 ? terc4_sym(r_aux) : SYM_GB_ODD;
`endif
                    // CTRL, reserved codes and (without TERC4) the island periods.
                    default:       w_sym_d = ctrl_sym(r_ctrl);
                endcase
            end
        end

        // Stage 2 registers: symbol and running disparity, cleared on reset or flush.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sym  <= '0;
                r_disp <= '0;
            end else if (!i_enable) begin
                r_sym  <= '0;
                r_disp <= '0;
            end else begin
                r_sym  <= w_sym_d;
                r_disp <= w_disp_d;
            end
        end

        assign o_symbol[10*g +: 10]            = r_sym;
        assign o_disparity[DISP_W*g +: DISP_W] = r_disp;
    end

endmodule

// File: tb/tb_h14tx_tmds_lane_encoder.sv
// Self-checking bench for h14tx_tmds_lane_encoder (LANES=4, DISP_W=5).
// A behavioural model predicts every output cycle into a queue at drive time; entries are
// popped and compared after each rising edge. Directed checks pin known symbol values.

module tb_h14tx_tmds_lane_encoder;

    localparam int LANES = 4;
    localparam int DW    = 5;

    localparam logic [2:0] M_CTRL   = 3'd0;
    localparam logic [2:0] M_VIDEO  = 3'd1;
    localparam logic [2:0] M_ISLAND = 3'd2;
    localparam logic [2:0] M_VGB    = 3'd3;
    localparam logic [2:0] M_IGB    = 3'd4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic [2:0]            mode;
    logic [8*LANES-1:0]    video;
    logic [2*LANES-1:0]    ctrl;
    logic [4*LANES-1:0]    aux;
    logic [10*LANES-1:0]   symbol;
    logic [DW*LANES-1:0]   disparity;

    always #5 clk = ~clk;

    h14tx_tmds_lane_encoder #(
        .LANES  (LANES),
        .DISP_W (DW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (en),
        .i_mode      (mode),
        .i_video     (video),
        .i_ctrl      (ctrl),
        .i_aux       (aux),
        .o_symbol    (symbol),
        .o_disparity (disparity)
    );

    typedef struct {
        logic [10*LANES-1:0] sym;
        logic [DW*LANES-1:0] disp;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] m_disp [LANES];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_model(input logic [1:0] c);
        logic [9:0] q;
        case (c)
            2'b00:   q = 10'b1101010100;
            2'b01:   q = 10'b0010101011;
            2'b10:   q = 10'b0101010100;
            default: q = 10'b1010101011;
        endcase
        return q;
    endfunction

    function automatic logic [9:0] terc4_model(input logic [3:0] d);
        logic [9:0] tab [16];
        tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        return tab[d];
    endfunction

    function automatic logic [9:0] video_model(input logic [7:0] v, input logic [DW-1:0] d_in,
                                               output logic [DW-1:0] d_out);
        int         cnt;
        int         n1;
        int         n0;
        int         d;
        logic       xn;
        logic       ir8;
        logic [7:0] ir;
        logic [9:0] q;
        cnt   = $countones(v);
        xn    = (cnt > 4) || (cnt == 4 && v[0] == 1'b0);
        ir    = '0;
        ir[0] = v[0];
        for (int i = 1; i < 8; i++) ir[i] = xn ? ~(ir[i-1] ^ v[i]) : (ir[i-1] ^ v[i]);
        ir8 = ~xn;
        n1  = $countones(ir);
        n0  = 8 - n1;
        d   = int'($signed(d_in));
        if (d == 0 || n1 == n0) begin
            q = {~ir8, ir8, ir8 ? ir : ~ir};
            d = d + (ir8 ? n1 - n0 : n0 - n1);
        end else if ((d > 0 && n1 > n0) || (d < 0 && n1 < n0)) begin
            q = {1'b1, ir8, ~ir};
            d = d + n0 - n1 + (ir8 ? 2 : 0);
        end else begin
            q = {1'b0, ir8, ir};
            d = d + n1 - n0 - (ir8 ? 0 : 2);
        end
        d_out = d[DW-1:0];
        return q;
    endfunction

    function automatic logic [9:0] lane_model(input int lane, input logic [2:0] md,
                                              input logic [7:0] v, input logic [1:0] c,
                                              input logic [3:0] a, input logic [DW-1:0] d_in,
                                              output logic [DW-1:0] d_out);
        logic [9:0] q;
        d_out = '0;
        case (md)
            M_VIDEO: q = video_model(v, d_in, d_out);
            M_VGB:   q = (lane % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
`ifdef H14TX_TMDS_TERC4_EN
            M_ISLAND: q = terc4_model(a);
            M_IGB:    q = (lane == 0) ? terc4_model(a) : 10'b0100110011;
`endif
            default: q = ctrl_model(c);
        endcase
        return q;
    endfunction

    // Pipeline emptied (reset): the next edge outputs zeros.
    task automatic sb_reset();
        exp_t z;
        z.sym  = '0;
        z.disp = '0;
        sb_q.delete();
        sb_q.push_back(z);
        for (int l = 0; l < LANES; l++) m_disp[l] = '0;
    endtask

    task automatic step(input logic e, input logic [2:0] md, input logic [8*LANES-1:0] v,
                        input logic [2*LANES-1:0] c, input logic [4*LANES-1:0] a);
        exp_t          ex;
        logic [DW-1:0] dn;
        en    = e;
        mode  = md;
        video = v;
        ctrl  = c;
        aux   = a;
        if (e) begin
            for (int l = 0; l < LANES; l++) begin
                ex.sym[10*l +: 10] = lane_model(l, md, v[8*l +: 8], c[2*l +: 2], a[4*l +: 4],
                                                m_disp[l], dn);
                ex.disp[DW*l +: DW] = dn;
                m_disp[l] = dn;
            end
        end else begin
            // Flush: the word already in stage 1 is discarded too.
            ex.sym  = '0;
            ex.disp = '0;
            if (sb_q.size() > 0) sb_q[sb_q.size()-1] = ex;
            for (int l = 0; l < LANES; l++) m_disp[l] = '0;
        end
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("scoreboard empty", 64'd0, 64'd1);
        end else begin
            ex = sb_q.pop_front();
            for (int l = 0; l < LANES; l++) begin
                check_val($sformatf("sym lane%0d", l), 64'(symbol[10*l +: 10]),
                          64'(ex.sym[10*l +: 10]));
                check_val($sformatf("disp lane%0d", l), 64'(disparity[DW*l +: DW]),
                          64'(ex.disp[DW*l +: DW]));
            end
        end
    endtask

    localparam logic [2*LANES-1:0] CTRL01 = {LANES{2'b01}};
    localparam logic [2*LANES-1:0] CTRL11 = {LANES{2'b11}};

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        mode  = M_CTRL;
        video = '0;
        ctrl  = '0;
        aux   = '0;
        #2 rst_n = 1'b0;
        #10;
        check_val("reset symbol", 64'(symbol), 64'd0);
        check_val("reset disparity", 64'(disparity), 64'd0);
        rst_n = 1'b1;
        sb_reset();

        // Control period, all ctrl = 01.
        step(1'b1, M_CTRL, '0, CTRL01, '0);
        check_val("ctrl first edge zero", 64'(symbol), 64'd0);
        step(1'b1, M_CTRL, '0, CTRL01, '0);
        check_val("ctrl01 symbols", 64'(symbol), 64'({LANES{10'b0010101011}}));
        step(1'b1, M_CTRL, '0, CTRL01, '0);
        check_val("ctrl disparity", 64'(disparity), 64'd0);

        // Video 0x00 three times, one control cycle, video again.
        step(1'b1, M_VIDEO, '0, CTRL01, '0);
        step(1'b1, M_VIDEO, '0, CTRL01, '0);
        check_val("v00 sym1", 64'(symbol[9:0]), 64'(10'b0100000000));
        check_val("v00 disp1", 64'(disparity[DW-1:0]), 64'(5'b11000));
        step(1'b1, M_VIDEO, '0, CTRL01, '0);
        check_val("v00 sym2", 64'(symbol[9:0]), 64'(10'b1111111111));
        check_val("v00 disp2", 64'(disparity[DW-1:0]), 64'(5'b00010));
        step(1'b1, M_CTRL, '0, CTRL01, '0);
        check_val("v00 sym3", 64'(symbol[9:0]), 64'(10'b0100000000));
        check_val("v00 disp3", 64'(disparity[DW-1:0]), 64'(5'b11010));
        step(1'b1, M_VIDEO, '0, CTRL01, '0);
        check_val("ctrl gap disp", 64'(disparity), 64'd0);
        step(1'b1, M_VIDEO, $urandom, CTRL01, '0);
        check_val("video restart sym", 64'(symbol[9:0]), 64'(10'b0100000000));

        for (int i = 0; i < 40; i++) step(1'b1, M_VIDEO, $urandom, 8'($urandom), '0);

        // Video guard band.
        step(1'b1, M_VGB, $urandom, 8'($urandom), '0);
        step(1'b1, M_VGB, $urandom, 8'($urandom), '0);
        check_val("video gb", 64'(symbol),
                  64'({10'b0100110011, 10'b1011001100, 10'b0100110011, 10'b1011001100}));

        // Data island, aux lane0 = B, lane1 = 0.
        step(1'b1, M_ISLAND, '0, CTRL11, 16'h750B);
        step(1'b1, M_ISLAND, '0, CTRL11, 16'h750B);
`ifdef H14TX_TMDS_TERC4_EN
        check_val("island lane0", 64'(symbol[9:0]), 64'(10'b1011000110));
        check_val("island lane1", 64'(symbol[19:10]), 64'(10'b1010011100));
`else
        check_val("island lane0", 64'(symbol[9:0]), 64'(10'b1010101011));
        check_val("island lane1", 64'(symbol[19:10]), 64'(10'b1010101011));
`endif

        for (int i = 0; i < 40; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), $urandom, 8'($urandom), 16'($urandom));
        end

        // Flush in mid-video.
        for (int i = 0; i < 5; i++) step(1'b1, M_VIDEO, $urandom, '0, '0);
        step(1'b0, M_VIDEO, $urandom, '0, '0);
        check_val("flush symbol", 64'(symbol), 64'd0);
        check_val("flush disparity", 64'(disparity), 64'd0);
        step(1'b1, M_VIDEO, 32'h0, '0, '0);
        check_val("flush resume zero", 64'(symbol), 64'd0);
        step(1'b1, M_VIDEO, $urandom, '0, '0);
        check_val("flush resume sym", 64'(symbol[9:0]), 64'(10'b0100000000));
        step(1'b1, M_VIDEO, $urandom, '0, '0);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check_val("async rst symbol", 64'(symbol), 64'd0);
        check_val("async rst disparity", 64'(disparity), 64'd0);
        #1 rst_n = 1'b1;
        sb_reset();
        step(1'b1, M_VIDEO, $urandom, '0, '0);
        check_val("post rst zero", 64'(symbol), 64'd0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] md;
            md = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : M_VIDEO;
            step($urandom_range(0, 11) != 0, md, $urandom, 8'($urandom), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
